// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-port program ROM arbiter.
// Holds default bus widths and the access FSM state encoding.
// No logic; imported by the arbiter top and its helpers.
package rom_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the port not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when a pick is consumed and updates last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic valid
);

    // Lone request wins outright; on a tie the port opposite 'last' wins.
    always_comb begin
        grant = req1 & (~req0 | ~last);
        valid = req0 | req1;
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read ports onto one shared combinational program ROM.
// Latency: req sampled in IDLE at edge N, data latched and ack pulsed after edge N+1.
// Backpressure: requester holds req until ack; a port is ineligible during its own ack cycle.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_data,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              m0_ack_d, m1_ack_d;
    logic [DATA_W-1:0] m0_data_d, m1_data_d;

    logic elig0, elig1;
    logic pick_grant, pick_valid;

    // A port whose ack is showing this cycle must not be re-served with the same request.
    always_comb begin
        elig0 = m0_req & ~m0_ack;
        elig1 = m1_req & ~m1_ack;
    end

    rr_pick2 u_pick (
        .req0  (elig0),
        .req1  (elig1),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // The ROM address comes straight from a register so it never glitches.
    always_comb rom_addr = addr_q;

    // Next-state and output decode: grant in IDLE, complete the read in ACCESS.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        grant_d   = grant_q;
        last_d    = last_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_data_d = m0_data;
        m1_data_d = m1_data;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    addr_d  = pick_grant ? m1_addr : m0_addr;
                    grant_d = pick_grant;
                    last_d  = pick_grant;
                end
            end
            ACCESS: begin
                // Completes even if the requester dropped req meanwhile.
                state_d = IDLE;
                if (grant_q) begin
                    m1_data_d = rom_data;
                    m1_ack_d  = 1'b1;
                end else begin
                    m0_data_d = rom_data;
                    m0_ack_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            m0_data <= '0;
            m1_data <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            m0_ack  <= m0_ack_d;
            m1_ack  <= m1_ack_d;
            m0_data <= m0_data_d;
            m1_data <= m1_data_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a behavioural program ROM.
// Directed scenarios first, then randomized requesters against a transaction model.
// Requesters hold req until ack; the model checks data, exclusivity, fairness and latency.
module tb_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        m0_req, m1_req;
    logic [15:0] m0_addr, m1_addr;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_data, m1_data;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    rom_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_ack   (m0_ack),
        .m0_data  (m0_data),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_ack   (m1_ack),
        .m1_data  (m1_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    // Program ROM contents: fixed words at the addresses of interest, a hash elsewhere.
    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        case (a)
            16'h0004: rom_fn = 32'h8000_0016;
            16'h0005: rom_fn = 32'h0014_085C;
            16'h000D: rom_fn = 32'h00FF_0216;
            16'h0010: rom_fn = 32'h0003_A004;
            16'hFFFF: rom_fn = 32'h0000_0000;
            default:  rom_fn = {a ^ 16'h5A3C, ~a};
        endcase
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        m0_req = 1'b0;
        m1_req = 1'b0;
        RST    = 1'b1;
        tick;
        tick;
        RST    = 1'b0;
    endtask

    logic [15:0] raddr [2];
    bit          pend  [2];
    int          wait_cnt [2];
    int          last_ack;
    bit          other_wait;
    bit          ackv;
    logic [31:0] datav;

    initial begin
        RST = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        #1;
        // Reset state
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack), 32'h0);
        chk("rst_m1_ack", 32'(m1_ack), 32'h0);
        chk("rst_m0_data", m0_data, 32'h0);
        chk("rst_m1_data", m1_data, 32'h0);
        do_reset;

        // Single uncontended read on port 0
        m0_req = 1'b1; m0_addr = 16'h0004;
        tick;
        chk("a_ack_early", 32'(m0_ack), 32'h0);
        chk("a_rom_addr", 32'(rom_addr), 32'h0004);
        tick;
        chk("a_ack", 32'(m0_ack), 32'h1);
        chk("a_data", m0_data, 32'h8000_0016);
        chk("a_m1_ack", 32'(m1_ack), 32'h0);
        m0_req = 1'b0;
        tick;
        chk("a_ack_once", 32'(m0_ack), 32'h0);
        chk("a_data_hold", m0_data, 32'h8000_0016);

        // Simultaneous requests: port 0 first after reset, then port 1
        do_reset;
        m0_req = 1'b1; m0_addr = 16'h0005; m1_req = 1'b1; m1_addr = 16'h000D;
        tick;
        chk("b_rom_addr0", 32'(rom_addr), 32'h0005);
        tick;
        chk("b_ack0", 32'(m0_ack), 32'h1);
        chk("b_ack1_off", 32'(m1_ack), 32'h0);
        chk("b_data0", m0_data, 32'h0014_085C);
        m0_req = 1'b0;
        tick;
        chk("b_rom_addr1", 32'(rom_addr), 32'h000D);
        chk("b_ack0_off", 32'(m0_ack), 32'h0);
        tick;
        chk("b_ack1", 32'(m1_ack), 32'h1);
        chk("b_ack0_excl", 32'(m0_ack), 32'h0);
        chk("b_data1", m1_data, 32'h00FF_0216);
        chk("b_data0_hold", m0_data, 32'h0014_085C);
        m1_req = 1'b0;

        // Both held continuously: acks alternate 0,1,0,1 every two cycles
        do_reset;
        m0_req = 1'b1; m0_addr = 16'h0005; m1_req = 1'b1; m1_addr = 16'h000D;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("c_ack0", 32'(m0_ack), 32'(k % 4 == 2));
            chk("c_ack1", 32'(m1_ack), 32'(k % 4 == 0));
        end
        chk("c_data0", m0_data, 32'h0014_085C);
        chk("c_data1", m1_data, 32'h00FF_0216);
        m0_req = 1'b0; m1_req = 1'b0;

        // Port 1 alone at the all-ones address
        do_reset;
        m1_req = 1'b1; m1_addr = 16'hFFFF;
        tick;
        chk("d_rom_addr", 32'(rom_addr), 32'hFFFF);
        tick;
        chk("d_ack1", 32'(m1_ack), 32'h1);
        chk("d_data1", m1_data, 32'h0);
        m1_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("d_ack1_once", 32'(m1_ack), 32'h0);
        end

        // Reset in the middle of a port 0 access
        do_reset;
        m0_req = 1'b1; m0_addr = 16'h0004;
        tick;
        tick;
        m0_req = 1'b0;
        tick;
        m0_req = 1'b1; m0_addr = 16'h000D;
        tick;
        chk("e_rom_addr", 32'(rom_addr), 32'h000D);
        #2 RST = 1'b1;
        #1;
        chk("e_rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("e_rst_data0", m0_data, 32'h0);
        chk("e_rst_ack0", 32'(m0_ack), 32'h0);
        chk("e_rst_ack1", 32'(m1_ack), 32'h0);
        m0_req = 1'b0;
        tick;
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("e_no_ack0", 32'(m0_ack), 32'h0);
        end

        // Port 0 holds req across its ack with a new address
        do_reset;
        m0_req = 1'b1; m0_addr = 16'h0004;
        tick;
        tick;
        chk("f_ack_first", 32'(m0_ack), 32'h1);
        chk("f_data_first", m0_data, 32'h8000_0016);
        m0_addr = 16'h0010;
        tick;
        chk("f_no_regrant", 32'(rom_addr), 32'h0004);
        chk("f_ack_off", 32'(m0_ack), 32'h0);
        tick;
        chk("f_regrant", 32'(rom_addr), 32'h0010);
        tick;
        chk("f_ack_second", 32'(m0_ack), 32'h1);
        chk("f_data_second", m0_data, 32'h0003_A004);
        m0_req = 1'b0;

        // Random requesters against a transaction-level model
        do_reset;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; wait_cnt[p] = 0; raddr[p] = '0;
        end
        last_ack   = -1;
        other_wait = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick;
            chk("rnd_ack_excl", 32'(m0_ack & m1_ack), 32'h0);
            for (int p = 0; p < 2; p++) begin
                ackv  = (p == 0) ? m0_ack : m1_ack;
                datav = (p == 0) ? m0_data : m1_data;
                if (ackv) begin
                    chk("rnd_ack_pending", 32'(pend[p]), 32'h1);
                    chk("rnd_data", datav, rom_fn(raddr[p]));
                    if (last_ack == p)
                        chk("rnd_round_robin", 32'(other_wait), 32'h0);
                    last_ack    = p;
                    pend[p]     = 1'b0;
                end else if (pend[p]) begin
                    wait_cnt[p]++;
                    chk("rnd_latency", 32'(wait_cnt[p] <= 6), 32'h1);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]     = 1'b1;
                    raddr[p]    = 16'($urandom);
                    wait_cnt[p] = 0;
                end
            end
            m0_req = pend[0]; m0_addr = raddr[0];
            m1_req = pend[1]; m1_addr = raddr[1];
            if (m0_ack) other_wait = pend[1];
            if (m1_ack) other_wait = pend[0];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, ROM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, ROM word width.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port m0_req  input  1  port 0 (instruction fetch) request, held high until m0_ack.
REQ-006 SHALL have port m0_addr  input  ADDR_W  port 0 word address, stable while m0_req is high.
REQ-007 SHALL have port m0_ack  output  1  one-cycle pulse, m0_data valid.
REQ-008 SHALL have port m0_data  output  DATA_W  registered read data for port 0.
REQ-009 SHALL have ports m1_req, m1_addr, m1_ack, m1_data, identical to REQ-005..008, for port 1 (loader/debug reader).
REQ-010 SHALL have port rom_addr  output  ADDR_W  address to the shared combinational ROM.
REQ-011 SHALL have port rom_data  input  DATA_W  combinational ROM output for rom_addr.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-013 In IDLE with at least one eligible request, SHALL pick a winner, capture its address into addr_q and its index into grant_q, and enter ACCESS on the next edge.
REQ-014 In IDLE with no eligible request, SHALL remain in IDLE with addr_q unchanged.
REQ-015 rom_addr SHALL equal addr_q at all times (registered, glitch-free).
REQ-016 In ACCESS, SHALL latch rom_data into the granted port's data register, assert that port's ack for exactly the next cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: req sampled in IDLE at edge N -> ack high during cycle N+2, when uncontended.
REQ-018 The non-granted port's data register SHALL hold its previous value.
REQ-019 A port SHALL be ineligible in the cycle its own ack is high, so a held req is not re-served with stale data. The other port remains eligible in that cycle.
REQ-020 When both ports are eligible, SHALL grant the port not granted most recently (round-robin); last_q updates on every grant.
REQ-021 A lone eligible request SHALL be granted regardless of last_q.
REQ-022 m0_ack and m1_ack SHALL never be high in the same cycle.
REQ-023 Requests dropped before grant SHALL be ignored. A req dropped during ACCESS SHALL still complete and ack; the requester discards the result.
REQ-024 Address wrap: addr_q SHALL pass any ADDR_W value, including all-ones, unmodified.

Reset
REQ-025 RST high SHALL immediately force: state IDLE, addr_q 0, grant_q 0, last_q 1 (port 0 wins the first tie), both acks 0, both data registers 0.
REQ-026 Reset asserted during ACCESS SHALL abort the access with no ack issued after release.
REQ-027 The first grant SHALL occur at the first rising edge after RST deasserts with a req high.

Structure
REQ-028 A shared package SHALL hold ADDR_W/DATA_W defaults and the FSM state enum (IDLE, ACCESS).
REQ-029 The round-robin choice SHALL be a sub-module rr_pick2, with inputs (req0, req1, last) and output (grant, valid), reusable by other two-way arbiters.
REQ-030 The design SHALL contain no ROM storage; the program ROM stays a separate module driven via rom_addr/rom_data.

Verification
REQ-031 Bench SHALL instantiate the program ROM on rom_addr/rom_data and cover these scenarios:
- After reset, m0_req=1, m0_addr=0x0004 -> m0_ack at cycle N+2, m0_data=0x80000016; m1_ack stays 0.
- m0 and m1 request in the same cycle, m0_addr=0x0005, m1_addr=0x000D -> m0 served first (0x0014085C), then m1 (0x00FF0216); acks are in distinct cycles.
- Both held continuously -> grants alternate 0,1,0,1; no port is served twice consecutively while the other is waiting.
- m1 alone, m1_addr=0xFFFF -> rom_addr=0xFFFF, m1_data=0x00000000, m1_ack pulses once.
- RST asserted during ACCESS for port 0 -> all outputs 0 immediately; no m0_ack after release until a new request.
- m0_req held across its ack with m0_addr changed to 0x0010 -> second grant no earlier than the cycle after the ack, m0_data=0x0003A004.
